// File: rtl/lcd_ctrl_p.sv
// LCD image controller: loads an N x N image from ROM, applies 2x2 window
// commands around an operation point, and streams the image to a result buffer.
module lcd_ctrl_p #(
  parameter  int DW    = 8,
  parameter  int LOG_N = 3,
  localparam int AW    = 2 * LOG_N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] IROM_Q,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [DW-1:0] IRB_D,
  output logic [AW-1:0] IRB_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = 1 << LOG_N;
  localparam int NN = N * N;

  localparam logic [AW-1:0]    LAST_A  = AW'(NN - 1);
  localparam logic [AW-1:0]    A_ONE   = AW'(1);
  localparam logic [AW:0]      LD_DONE = (AW + 1)'(NN);
  localparam logic [AW:0]      LD_ONE  = (AW + 1)'(1);
  localparam logic [LOG_N-1:0] MID     = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] P_MAX   = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] P_ONE   = LOG_N'(1);

  localparam logic [3:0] CMD_WRITE  = 4'd0;
  localparam logic [3:0] CMD_UP     = 4'd1;
  localparam logic [3:0] CMD_DOWN   = 4'd2;
  localparam logic [3:0] CMD_LEFT   = 4'd3;
  localparam logic [3:0] CMD_RIGHT  = 4'd4;
  localparam logic [3:0] CMD_AVG    = 4'd5;
  localparam logic [3:0] CMD_MIRX   = 4'd6;
  localparam logic [3:0] CMD_MIRY   = 4'd7;
  localparam logic [3:0] CMD_MAX    = 4'd8;
  localparam logic [3:0] CMD_MIN    = 4'd9;
  localparam logic [3:0] CMD_ROTCW  = 4'd10;
  localparam logic [3:0] CMD_ROTCCW = 4'd11;
  localparam logic [3:0] CMD_ORIGIN = 4'd12;

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    img_q [NN];
  logic [AW:0]      ld_cnt_q, ld_cnt_d;
  logic [AW-1:0]    rom_a_q, rom_a_d;
  logic [AW-1:0]    wr_a_q, wr_a_d;
  logic [LOG_N-1:0] x_q, x_d, y_q, y_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             done_q, done_d;

  logic [AW-1:0]    ld_addr;
  logic [AW-1:0]    win_a [4];
  logic [DW-1:0]    win_p [4];
  logic [DW-1:0]    win_n [4];
  logic             win_we;
  logic [DW+1:0]    win_sum;
  logic [DW-1:0]    win_max, win_min;

  // Window taps in order TL, TR, BL, BR relative to the point (X,Y)
  for (genvar gi = 0; gi < 4; gi++) begin : g_win
    localparam logic [LOG_N-1:0] DY = LOG_N'(1 - gi / 2);
    localparam logic [LOG_N-1:0] DX = LOG_N'(1 - gi % 2);
    assign win_a[gi] = {y_q - DY, x_q - DX};
    assign win_p[gi] = img_q[win_a[gi]];
  end

  // ROM data arrives one cycle after its address, so store lags the counter by one
  assign ld_addr = ld_cnt_q[AW-1:0] - A_ONE;

  always_comb begin
    win_sum = {2'b00, win_p[0]} + {2'b00, win_p[1]} + {2'b00, win_p[2]} + {2'b00, win_p[3]};
    win_max = win_p[0];
    win_min = win_p[0];
    for (int j = 1; j < 4; j++) begin
      if (win_p[j] > win_max) win_max = win_p[j];
      if (win_p[j] < win_min) win_min = win_p[j];
    end
    win_n  = win_p;
    win_we = 1'b0;
    case (cmd_q)
      CMD_AVG: begin
        for (int j = 0; j < 4; j++) win_n[j] = win_sum[DW+1:2];
        win_we = 1'b1;
      end
      CMD_MAX: begin
        for (int j = 0; j < 4; j++) win_n[j] = win_max;
        win_we = 1'b1;
      end
      CMD_MIN: begin
        for (int j = 0; j < 4; j++) win_n[j] = win_min;
        win_we = 1'b1;
      end
      CMD_MIRX: begin
        win_n  = '{win_p[2], win_p[3], win_p[0], win_p[1]};
        win_we = 1'b1;
      end
      CMD_MIRY: begin
        win_n  = '{win_p[1], win_p[0], win_p[3], win_p[2]};
        win_we = 1'b1;
      end
      CMD_ROTCW: begin
        win_n  = '{win_p[2], win_p[0], win_p[3], win_p[1]};
        win_we = 1'b1;
      end
      CMD_ROTCCW: begin
        win_n  = '{win_p[1], win_p[3], win_p[0], win_p[2]};
        win_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Image buffer is never cleared by reset; a reload overwrites every entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_LOAD && ld_cnt_q != '0) begin
        img_q[ld_addr] <= IROM_Q;
      end else if (state_q == S_EXEC && win_we) begin
        for (int j = 0; j < 4; j++) img_q[win_a[j]] <= win_n[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (ld_cnt_q == LD_DONE) state_d = S_IDLE;
      S_IDLE:  if (cmd_valid) state_d = (cmd == CMD_WRITE) ? S_WRITE : S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      S_WRITE: if (wr_a_q == LAST_A) state_d = S_IDLE;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    IROM_EN = (state_q != S_LOAD);
    busy    = (state_q != S_IDLE);
    IRB_RW  = (state_q != S_WRITE);
    IRB_D   = (state_q == S_WRITE) ? img_q[wr_a_q] : '0;
  end

  assign IROM_A = rom_a_q;
  assign IRB_A  = wr_a_q;
  assign done   = done_q;

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    rom_a_d  = rom_a_q;
    wr_a_d   = wr_a_q;
    x_d      = x_q;
    y_d      = y_q;
    cmd_d    = cmd_q;
    done_d   = done_q;
    case (state_q)
      S_LOAD: begin
        if (ld_cnt_q != LD_DONE) ld_cnt_d = ld_cnt_q + LD_ONE;
        if (rom_a_q != LAST_A)   rom_a_d  = rom_a_q + A_ONE;
      end
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d  = cmd;
          done_d = 1'b0;
          wr_a_d = '0;
        end
      end
      S_EXEC: begin
        case (cmd_q)
          CMD_UP:     if (y_q > P_ONE) y_d = y_q - P_ONE;
          CMD_DOWN:   if (y_q < P_MAX) y_d = y_q + P_ONE;
          CMD_LEFT:   if (x_q > P_ONE) x_d = x_q - P_ONE;
          CMD_RIGHT:  if (x_q < P_MAX) x_d = x_q + P_ONE;
          CMD_ORIGIN: begin
            x_d = MID;
            y_d = MID;
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        if (wr_a_q == LAST_A) done_d = 1'b1;
        else                  wr_a_d = wr_a_q + A_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt_q <= '0;
      rom_a_q  <= '0;
      wr_a_q   <= '0;
      x_q      <= MID;
      y_q      <= MID;
      cmd_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      rom_a_q  <= rom_a_d;
      wr_a_q   <= wr_a_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cmd_q    <= cmd_d;
      done_q   <= done_d;
    end
  end

endmodule
